// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: assembles a little-endian byte stream into
// 32-bit words, writes them from address 0 upward, and stalls fetch while loading.
module imem_load_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_stall,
  output logic              fetch_fault,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE = 1;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [23:0]       assemble_reg;

  logic              len_ok;
  logic [ADDR_W:0]   len_m1;
  logic              accept;
  logic              in_idle;
  logic              addr_bad;

  assign len_ok  = (load_len != '0) && (load_len <= DEPTH_W);
  assign len_m1  = load_len - LEN_ONE;
  assign accept  = byte_valid & byte_ready;
  assign in_idle = (state == IDLE);

  assign addr_bad    = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0);
  assign fetch_fault = in_idle & fetch_req & addr_bad;
  assign fetch_stall = busy;

  // Outside IDLE the read port shows the most recently written word.
  assign mem_raddr = in_idle ? fetch_addr[ADDR_W+1:2] : mem_waddr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      word_idx     <= '0;
      last_idx     <= '0;
      assemble_reg <= '0;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (load_start) begin
            if (len_ok) begin
              last_idx     <= len_m1[ADDR_W-1:0];
              word_idx     <= '0;
              byte_cnt     <= '0;
              assemble_reg <= '0;
              mem_waddr    <= '0;
              state        <= LOAD;
              busy         <= 1'b1;
              byte_ready   <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        LOAD: begin
          // Abort wins over a byte in the same cycle, so a partial word never lands.
          if (load_abort) begin
            state        <= IDLE;
            err          <= 1'b1;
            busy         <= 1'b0;
            byte_ready   <= 1'b0;
            byte_cnt     <= '0;
            assemble_reg <= '0;
          end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: assemble_reg[7:0]   <= byte_data;
              2'd1: assemble_reg[15:8]  <= byte_data;
              2'd2: assemble_reg[23:16] <= byte_data;
              default: begin
                mem_we    <= 1'b1;
                mem_waddr <= word_idx;
                mem_wdata <= {byte_data, assemble_reg};
                // The index is held on the final word so it never passes DEPTH-1.
                if (word_idx == last_idx) begin
                  state      <= DONE;
                  done       <= 1'b1;
                  byte_ready <= 1'b0;
                end else begin
                  word_idx <= word_idx + IDX_ONE;
                end
              end
            endcase
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: fetch pass-through vectors plus load,
// reject, abort and reset sequences checked against a write scoreboard.
module tb_imem_load_ctrl;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_abort;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              fetch_stall;
  logic              fetch_fault;
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic              req;
    logic [31:0]       addr;
    logic              fault;
    logic [ADDR_W-1:0] raddr;
  } fetch_vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              last;
  } wr_t;

  wr_t        expq[$];
  fetch_vec_t vecs[8];

  imem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_len    (load_len),
    .load_abort  (load_abort),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_fault (fetch_fault),
    .mem_raddr   (mem_raddr),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input fetch_vec_t v);
    fetch_req  = v.req;
    fetch_addr = v.addr;
    @(negedge clk);
  endtask

  task automatic pushWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic last);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.last = last;
    expq.push_back(e);
  endtask

  task automatic startLoad(input logic [ADDR_W:0] len);
    load_start = 1'b1;
    load_len   = len;
    tick();
    load_start = 1'b0;
  endtask

  // Holds byte_valid until the controller takes the byte, bounded so a stuck DUT fails.
  task automatic sendByte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) checkOutput("byte_ready_timeout", 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write actual addr=%0d data=0x%08h expected=no write", mem_waddr, mem_wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        checkOutput("wr_addr", 32'(mem_waddr), 32'(e.addr));
        checkOutput("wr_data", mem_wdata, e.data);
        checkOutput("wr_done", 32'(done), 32'(e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{req: 1'b1, addr: 32'h0000_0006, fault: 1'b1, raddr: 10'd1};
    vecs[1] = '{req: 1'b1, addr: 32'h0000_1000, fault: 1'b1, raddr: 10'd0};
    vecs[2] = '{req: 1'b1, addr: 32'h0000_0FFC, fault: 1'b0, raddr: 10'd1023};
    vecs[3] = '{req: 1'b0, addr: 32'h0000_0006, fault: 1'b0, raddr: 10'd1};
    vecs[4] = '{req: 1'b1, addr: 32'h0000_0010, fault: 1'b0, raddr: 10'd4};
    vecs[5] = '{req: 1'b1, addr: 32'h8000_0000, fault: 1'b1, raddr: 10'd0};
    vecs[6] = '{req: 1'b1, addr: 32'h0000_0003, fault: 1'b1, raddr: 10'd0};
    vecs[7] = '{req: 1'b1, addr: 32'h0000_07F8, fault: 1'b0, raddr: 10'd510};

    rst        = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    load_abort = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    fetch_req  = 1'b0;
    fetch_addr = 32'h10;

    // Reset held for two cycles while the other inputs toggle.
    repeat (2) begin
      tick();
      load_start = ~load_start;
      load_len   = 11'd2;
      load_abort = ~load_abort;
      byte_valid = ~byte_valid;
      byte_data  = 8'hAA;
      fetch_req  = 1'b1;
    end
    @(negedge clk);
    checkOutput("rst_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_stall", 32'(fetch_stall), 32'd0);
    checkOutput("rst_raddr", 32'(mem_raddr), 32'd4);
    tick();
    rst        = 1'b1;
    load_start = 1'b0;
    load_abort = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    fetch_req  = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    // Fetch pass-through and fault decode in IDLE.
    for (int i = 0; i < 8; i++) begin
      tick();
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].fault));
      checkOutput($sformatf("vec%0d_raddr", i), 32'(mem_raddr), 32'(vecs[i].raddr));
    end

    // Two-word load with gaps; a load_start mid-load must be ignored.
    tick();
    fetch_req  = 1'b1;
    fetch_addr = 32'h12;
    pushWrite(10'd0, 32'h0050_0513, 1'b0);
    pushWrite(10'd1, 32'h0073_02B3, 1'b1);
    load_start = 1'b1;
    load_len   = 11'd2;
    @(negedge clk);
    checkOutput("start_cycle_stall", 32'(fetch_stall), 32'd0);
    tick();
    load_start = 1'b0;
    @(negedge clk);
    checkOutput("load_stall", 32'(fetch_stall), 32'd1);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_fault_masked", 32'(fetch_fault), 32'd0);
    checkOutput("load_byte_ready", 32'(byte_ready), 32'd1);
    sendByte(8'h13, 0);
    sendByte(8'h05, 2);
    sendByte(8'h50, 0);
    sendByte(8'h00, 1);
    startLoad(11'd0);
    @(negedge clk);
    checkOutput("start_ignored_err", 32'(err), 32'd0);
    checkOutput("start_ignored_busy", 32'(busy), 32'd1);
    sendByte(8'hB3, 1);
    sendByte(8'h02, 0);
    sendByte(8'h73, 3);
    sendByte(8'h00, 0);
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_byte_ready", 32'(byte_ready), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_stall", 32'(fetch_stall), 32'd1);
    checkOutput("done_raddr", 32'(mem_raddr), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("after_done_stall", 32'(fetch_stall), 32'd0);
    checkOutput("after_done_busy", 32'(busy), 32'd0);
    checkOutput("after_done_done", 32'(done), 32'd0);
    checkOutput("after_done_raddr", 32'(mem_raddr), 32'd4);
    checkOutput("after_done_fault", 32'(fetch_fault), 32'd1);
    fetch_req = 1'b0;

    // Rejected lengths: zero and DEPTH+1.
    for (int k = 0; k < 2; k++) begin
      tick();
      startLoad(k == 0 ? 11'd0 : 11'(DEPTH + 1));
      @(negedge clk);
      checkOutput($sformatf("reject%0d_err", k), 32'(err), 32'd1);
      checkOutput($sformatf("reject%0d_busy", k), 32'(busy), 32'd0);
      tick();
      @(negedge clk);
      checkOutput($sformatf("reject%0d_err_clear", k), 32'(err), 32'd0);
    end

    // Abort after six bytes of a three-word load; only word 0 is written.
    tick();
    pushWrite(10'd0, 32'h4433_2211, 1'b0);
    startLoad(11'd3);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    sendByte(8'h33, 1);
    sendByte(8'h44, 0);
    sendByte(8'h55, 0);
    sendByte(8'h66, 2);
    load_abort = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    tick();
    load_abort = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_err", 32'(err), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_byte_ready", 32'(byte_ready), 32'd0);
    repeat (3) tick();

    // Abort coinciding with the byte that would complete a word.
    startLoad(11'd2);
    sendByte(8'hA1, 0);
    sendByte(8'hA2, 0);
    sendByte(8'hA3, 0);
    load_abort = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hA4;
    tick();
    load_abort = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_prio_err", 32'(err), 32'd1);
    checkOutput("abort_prio_we", 32'(mem_we), 32'd0);
    repeat (3) tick();

    // Reset mid-load, bytes offered in IDLE, then a fresh one-word load.
    startLoad(11'd3);
    sendByte(8'hDE, 0);
    sendByte(8'hAD, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_byte_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("idle_byte_ready", 32'(byte_ready), 32'd0);
    tick();
    byte_valid = 1'b0;
    pushWrite(10'd0, 32'h0062_E233, 1'b1);
    startLoad(11'd1);
    sendByte(8'h33, 0);
    sendByte(8'hE2, 1);
    sendByte(8'h62, 0);
    sendByte(8'h00, 0);
    load_abort = 1'b1;
    @(negedge clk);
    checkOutput("final_done", 32'(done), 32'd1);
    checkOutput("final_busy", 32'(busy), 32'd1);
    tick();
    load_abort = 1'b0;
    @(negedge clk);
    checkOutput("done_abort_ignored", 32'(err), 32'd0);
    checkOutput("final_idle_busy", 32'(busy), 32'd0);

    repeat (3) tick();
    checkOutput("queue_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Controller that owns the write side of the instruction memory and sequences program loading into it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive word addresses starting at 0.
- Stalls instruction fetch while a load is in progress. In IDLE, fetch addresses pass through to the memory read port.

Parameters:
- DEPTH, 1024, instruction memory depth in 32-bit words.
- ADDR_W, 10, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset (0 = reset).
- load_start  input  1  one-cycle request to begin a load.
- load_len  input  ADDR_W+1  number of words to load; sampled with load_start.
- load_abort  input  1  abort an in-progress load.
- byte_valid  input  1  stream byte valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  controller accepts a byte this cycle.
- fetch_req  input  1  fetch stage requests an instruction.
- fetch_addr  input  32  byte address from the PC.
- fetch_stall  output  1  fetch must hold its PC.
- fetch_fault  output  1  fetch address is misaligned or out of range.
- mem_raddr  output  ADDR_W  memory read word address.
- mem_we  output  1  memory write enable.
- mem_waddr  output  ADDR_W  memory write word address.
- mem_wdata  output  32  memory write data.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  one-cycle pulse on a rejected or aborted load.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State is IDLE.
  - byte counter, word index, and assembly register are 0.
  - byte_ready, mem_we, mem_waddr, mem_wdata, busy, done, and err are 0.
  - Reset mid-load discards all partial state; no further mem_we is issued.
- States: IDLE, LOAD, DONE.
- IDLE:
  - fetch_stall = 0.
  - mem_raddr = fetch_addr[ADDR_W+1:2] (combinational).
  - fetch_fault = fetch_req & (fetch_addr[1:0] != 0 | fetch_addr[31:ADDR_W+2] != 0) (combinational). fetch_fault is 0 outside IDLE.
  - load_start with 1 <= load_len <= DEPTH: latch load_len, clear the word index and byte counter, go to LOAD, busy = 1 from the next cycle.
  - load_start with load_len == 0 or load_len > DEPTH: err = 1 for the next cycle; state stays IDLE.
- LOAD:
  - byte_ready = 1 and fetch_stall = 1. mem_raddr holds the word index of the last write.
  - A byte is accepted on a cycle where byte_valid & byte_ready.
  - The byte counter selects the lane: byte 0 goes to [7:0] ... byte 3 goes to [31:24].
  - When byte 3 is accepted in cycle N, in cycle N+1:
    - mem_we = 1 for exactly one cycle;
    - mem_wdata = the assembled word;
    - mem_waddr = the current word index.
    - The word index then increments and the byte counter wraps to 0.
  - If the accepted byte completes word load_len-1, go to DONE.
  - load_start is ignored in LOAD.
  - load_abort:
    - go to IDLE; err = 1 next cycle;
    - the partial word is discarded and no mem_we is issued for it;
    - load_abort has priority over a byte accepted in the same cycle.
- DONE (one cycle):
  - mem_we of the final word and done = 1 occur in this cycle.
  - byte_ready = 0, fetch_stall = 1, busy = 1.
  - load_abort is ignored; the next state is IDLE.
- busy = 1 in LOAD and DONE; 0 in IDLE.
- The word index never exceeds DEPTH-1; there is no wrap-around.
- Bytes presented outside LOAD see byte_ready = 0 and are not consumed.

Test Plan:
- Reset with rst=0 for 2 cycles, all inputs toggling -> all outputs 0, fetch_stall 0; fetch_addr=0x10 gives mem_raddr=4.
- load_start with load_len=2, bytes 0x13,0x05,0x50,0x00,0xB3,0x02,0x73,0x00 with gaps in byte_valid -> two mem_we pulses: addr 0 data 0x00500513, addr 1 data 0x007302B3. The second pulse coincides with done=1; fetch_stall is 1 from the cycle after load_start until the cycle after done.
- load_len=0 and load_len=DEPTH+1 -> err pulse, busy stays 0, no mem_we.
- load_len=3, load_abort after 6 bytes -> one mem_we at addr 0, err pulse, IDLE; the partial word at addr 1 is never written.
- rst=0 after 2 bytes of a load -> no mem_we. A subsequent load_len=1 with 0x33,0xE2,0x62,0x00 -> mem_we at addr 0 data 0x0062E233.
- In IDLE, fetch_req with fetch_addr=0x6 -> fetch_fault=1. fetch_addr=0x1000 (DEPTH=1024) -> fetch_fault=1. fetch_addr=0xFFC -> fetch_fault=0, mem_raddr=1023.
